uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Receives 8N1 serial frames on the rx pin and presents each byte on a valid/ready output port. It sits directly downstream of the board rx pin and feeds the echo and command logic. It synchronises rx, rejects glitches with a 3-sample majority vote at mid-bit, and flags framing errors and overruns.

Parameters:
clock_frequency, 12000000, system clock frequency in Hz
baud_rate, 9600, serial bit rate in bit/s
Derived, not overridable:
- CLKS_PER_BIT = clock_frequency/baud_rate (integer division; 1250 at defaults).
- HALF = CLKS_PER_BIT/2 (625 at defaults).
- CLKS_PER_BIT < 8 is illegal; elaboration must fail.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
rx  input  1  serial line, asynchronous to clk, idles high
data  output  8  received byte, LSB received first
data_valid  output  1  data holds an unconsumed byte
data_ready  input  1  consumer accepts data this cycle
framing_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: unconsumed byte overwritten
busy  output  1  high in every state except IDLE

Behaviour:
- One clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values:
  - data=0x00, data_valid=0, framing_error=0, overrun=0, busy=0.
  - Both synchroniser flops and rx_prev = 1.
  - state=IDLE; counters = 0.
- Synchroniser: 2 flops feed rx_s. rx_prev holds rx_s delayed by one cycle.
- Bit timer cnt counts 0..CLKS_PER_BIT-1 and wraps to 0. A bit index 0..7 tracks DATA.
- Sampling: samples of rx_s are taken at cnt = HALF-1, HALF and HALF+1. The decision is made at cnt = HALF+1 on the majority of the three samples.
- State machine:
  - IDLE: on rx_prev=1 and rx_s=0, go to START with cnt=0.
  - START: at decision, majority 0 → continue; majority 1 → IDLE (glitch rejected, nothing reported). At cnt=CLKS_PER_BIT-1 → DATA, bit index 0.
  - DATA: at decision, shift the majority into the shift register, LSB first. At cnt wrap, increment the bit index. After bit 7's period ends → STOP.
  - STOP, majority 1 at decision: data ← shift register, data_valid ← 1, then → IDLE. The rest of the stop bit is not waited for, so back-to-back frames resync on the next falling edge.
  - STOP, majority 0 at decision: framing_error pulses 1 cycle, the byte is discarded → WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1, then → IDLE. This covers line breaks.
- Output handshake:
  - data_valid stays high until a rising edge with data_valid && data_ready; it is low the next cycle.
  - data is stable while data_valid=1.
- Delivery while data_valid=1 and not accepted that cycle: data is overwritten and overrun pulses 1 cycle.
- Acceptance and delivery on the same edge: the new byte wins, data_valid stays 1, no overrun.
- Latency: data_valid rises 9*CLKS_PER_BIT + HALF + 4 cycles (±1) after the rx pin falls, i.e. 11879 ± 1 at defaults.
- Reset mid-frame: immediate return to reset values, partial byte lost. After release the block waits for a fresh falling edge. Because rx_prev resets to 1, a line that is already low right after release is treated as a start edge.

Test Plan:
1. Send 0x55 at 1250 cycles/bit (start 0; data 1,0,1,0,1,0,1,0; stop 1), data_ready=0 → data=0x55, data_valid=1 at 11879±2 cycles after the start edge; framing_error and overrun stay 0; busy low after the STOP decision.
2. Drive rx low for 300 cycles then high → no data_valid; busy high then low by ~630 cycles after the edge; state back in IDLE.
3. Send 0x00 with the stop bit held low for 3000 cycles, then a clean 0xA3 → one framing_error pulse, no data_valid for 0x00; data=0xA3 delivered correctly afterwards.
4. Send 0x12 then 0x34 back-to-back with data_ready=0 → overrun pulses once, data=0x34, data_valid=1.
5. Hold data_ready=1 and send 0xF0, 0x0F → data_valid is a single-cycle pulse per byte with data=0xF0, then 0x0F; no overrun.
6. Assert rst_n low during data bit 4 of a frame, release, wait 2 bit times with rx=1, send 0x3C → all outputs 0 during reset; only 0x3C is delivered, no framing_error.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx -- 8N1 serial receiver with valid/ready byte output.
//
// The rx pin is brought into the clk domain through a two-flop synchroniser.
// Each bit is sampled three times around its centre. The majority of those
// three samples decides the bit, which rejects short glitches. A start bit
// that does not hold low at its centre is discarded silently. A low stop bit
// raises framing_error and drops the byte. If a new byte arrives while the
// previous one is still unconsumed, the old byte is replaced and overrun
// pulses.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   rx             serial line (asynchronous, idles high)
//   data[7:0]      received byte, LSB received first
//   data_valid     data holds an unconsumed byte
//   data_ready     consumer accepts data this cycle
//   framing_error  one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: unconsumed byte overwritten
//   busy           high whenever the receiver is not idle
module uart_rx #(
    parameter int clock_frequency = 12000000,
    parameter int baud_rate       = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clock_frequency / baud_rate;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    generate
        if (CLKS_PER_BIT < 8) begin : g_bad_rate
            $error("uart_rx: clock_frequency/baud_rate must be at least 8");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(HALF + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             rx_p0;
    logic             rx_s;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             smp_a;
    logic             smp_b;
    logic [7:0]       shreg;

    logic             decide;
    logic             cnt_last;
    logic             maj;
    logic             shift_en;
    logic             deliver;
    logic             frame_bad;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ---- stage: rx synchroniser and edge history ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_p0   <= rx;
            rx_s    <= rx_p0;
            rx_prev <= rx_s;
        end
    end

    // The third sample is the live rx_s at the decision count.
    assign decide   = (cnt == SMP_C);
    assign cnt_last = (cnt == CNT_LAST);
    assign maj      = majority3(smp_a, smp_b, rx_s);

    // ---- stage: frame state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_nxt = IDLE;
                end else if (cnt_last) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (cnt_last && (bit_idx == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            STOP: begin
                if (decide) begin
                    state_nxt = maj ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        shift_en  = (state == DATA) && decide;
        deliver   = (state == STOP) && decide && maj;
        frame_bad = (state == STOP) && decide && !maj;
    end

    // ---- stage: bit timing, sampling and shift register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            smp_a   <= 1'b1;
            smp_b   <= 1'b1;
            shreg   <= 8'h00;
        end else begin
            // Hold the timer at zero outside a frame so START always begins at 0.
            if (state_nxt == IDLE || state_nxt == WAIT_IDLE || cnt_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state == START) begin
                bit_idx <= 3'd0;
            end else if (state == DATA && cnt_last) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (cnt == SMP_A) begin
                smp_a <= rx_s;
            end
            if (cnt == SMP_B) begin
                smp_b <= rx_s;
            end

            if (shift_en) begin
                shreg <= {maj, shreg[7:1]};
            end
        end
    end

    // ---- stage: output holding register and handshake ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data          <= 8'h00;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_bad;
            overrun       <= 1'b0;
            if (deliver) begin
                // A byte accepted on this same edge is not an overrun.
                data       <= shreg;
                data_valid <= 1'b1;
                overrun    <= data_valid && !data_ready;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    // 250 clocks per bit keeps the run short; the bit-time ratios match the
    // 1250-clock default.
    localparam int CLK_HZ = 2400000;
    localparam int BAUD   = 9600;
    localparam int C      = CLK_HZ / BAUD;
    localparam int H      = C / 2;
    localparam int LAT    = 9 * C + H + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx #(
        .clock_frequency(CLK_HZ),
        .baud_rate      (BAUD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .data         (data),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];

    int         deliveries = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         vcyc = 0;
    int         last_deliv_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Scoreboard monitor: a new byte is presented when valid rises, when the
    // byte changes under valid, or when valid stays high right after a handshake.
    initial begin
        logic       v_prev;
        logic       hs_prev;
        logic [7:0] d_prev;
        v_prev  = 1'b0;
        hs_prev = 1'b0;
        d_prev  = 8'h00;
        forever begin
            @(negedge clk);
            if (data_valid && (!v_prev || hs_prev || data != d_prev)) begin
                deliveries++;
                last_deliv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_byte", int'(data), -1);
                end else begin
                    check("sb_data", int'(data), int'(exp_q.pop_front()));
                end
            end
            if (framing_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (data_valid) vcyc++;
            v_prev  = data_valid;
            d_prev  = data;
            hs_prev = data_valid && data_ready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: cycle=%0d expected finish before 100000", cyc);
        $fatal(1, "watchdog expired");
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic push,
                              input logic stop_val, input int stop_len);
        if (push) exp_q.push_back(b);
        drive(1'b0, C);
        for (int i = 0; i < 8; i++) drive(b[i], C);
        drive(stop_val, stop_len);
    endtask

    task automatic accept();
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_data"}, int'(data), 0);
        check({pfx, "_valid"}, int'(data_valid), 0);
        check({pfx, "_ferr"}, int'(framing_error), 0);
        check({pfx, "_ovr"}, int'(overrun), 0);
        check({pfx, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int d0, f0, o0, v0, t0, lat;

        // Reset state
        rst_n = 1'b0;
        rx = 1'b1;
        data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        drive(1'b1, 2 * C);

        // 1: single byte, not consumed; latency and status
        d0 = deliveries; f0 = fe_cnt; o0 = ov_cnt;
        t0 = cyc;
        send_frame(8'h55, 1'b1, 1'b1, C);
        lat = last_deliv_cyc - t0;
        check("t1_count", deliveries - d0, 1);
        check("t1_data", int'(data), 'h55);
        check("t1_valid", int'(data_valid), 1);
        check("t1_ferr", fe_cnt - f0, 0);
        check("t1_ovr", ov_cnt - o0, 0);
        check("t1_busy", int'(busy), 0);
        check("t1_latency_in_window", int'(lat >= LAT - 2 && lat <= LAT + 2), 1);
        accept();
        check("t1_valid_after_accept", int'(data_valid), 0);

        // 2: short start glitch is rejected
        d0 = deliveries; f0 = fe_cnt;
        drive(1'b0, (300 * C) / 1250);
        check("t2_busy_during", int'(busy), 1);
        drive(1'b1, H + 10);
        check("t2_busy_after", int'(busy), 0);
        check("t2_count", deliveries - d0, 0);
        check("t2_ferr", fe_cnt - f0, 0);
        drive(1'b1, C);

        // 3: break on stop bit, then a clean byte
        d0 = deliveries; f0 = fe_cnt;
        send_frame(8'h00, 1'b0, 1'b0, (3000 * C) / 1250);
        check("t3_ferr", fe_cnt - f0, 1);
        check("t3_count_bad", deliveries - d0, 0);
        check("t3_valid_bad", int'(data_valid), 0);
        drive(1'b1, 2 * C);
        send_frame(8'hA3, 1'b1, 1'b1, C);
        check("t3_count_good", deliveries - d0, 1);
        check("t3_data", int'(data), 'hA3);
        check("t3_ferr_once", fe_cnt - f0, 1);
        accept();

        // 4: back-to-back bytes without consumption
        d0 = deliveries; o0 = ov_cnt;
        send_frame(8'h12, 1'b1, 1'b1, C);
        send_frame(8'h34, 1'b1, 1'b1, C);
        check("t4_count", deliveries - d0, 2);
        check("t4_ovr", ov_cnt - o0, 1);
        check("t4_data", int'(data), 'h34);
        check("t4_valid", int'(data_valid), 1);
        accept();
        check("t4_valid_after_accept", int'(data_valid), 0);

        // 5: consumer always ready
        d0 = deliveries; o0 = ov_cnt; v0 = vcyc;
        data_ready = 1'b1;
        send_frame(8'hF0, 1'b1, 1'b1, C);
        send_frame(8'h0F, 1'b1, 1'b1, C);
        data_ready = 1'b0;
        check("t5_count", deliveries - d0, 2);
        check("t5_valid_cycles", vcyc - v0, 2);
        check("t5_ovr", ov_cnt - o0, 0);
        check("t5_data", int'(data), 'h0F);
        check("t5_valid", int'(data_valid), 0);

        // 6: reset in the middle of data bit 4
        d0 = deliveries; f0 = fe_cnt;
        drive(1'b0, C);
        for (int i = 0; i < 4; i++) drive(1'b0, C);
        drive(1'b1, C / 2);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("t6_rst");
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 2 * C);
        send_frame(8'h3C, 1'b1, 1'b1, C);
        check("t6_count", deliveries - d0, 1);
        check("t6_data", int'(data), 'h3C);
        check("t6_ferr", fe_cnt - f0, 0);
        accept();

        drive(1'b1, 10);
        check("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
